branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the pipelined RISC-V core.
- Replaces the current static not-taken policy, in which the branch is resolved in ID and IF/ID is flushed on a taken branch.
- IF performs a zero-latency lookup indexed by PC. Bimodal or gshare indexing is selected by MODE.
- ID returns the resolved outcome one or more cycles later, with the table index that was used at lookup. The block trains a table of saturating counters, a global history register, and branch/mispredict statistics.

---
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a table of saturating counters indexed by PC (bimodal)
// or PC XOR global history (gshare), trained by resolved outcomes from ID.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 4,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2,
  parameter int MODE     = 0,
  parameter int GHR_W    = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   lookup_pc_i,
  output logic              predict_taken_o,
  output logic [IDX_W-1:0]  predict_idx_o,
  input  logic              update_valid_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_taken_i,
  input  logic              update_pred_i,
  output logic              mispredict_o,
  output logic [GHR_W-1:0]  ghr_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES*CTR_W-1:0] w_ctr_flat;
  logic [IDX_W-1:0]         w_pc_idx;
  logic [IDX_W-1:0]         w_lookup_idx;
  logic [CTR_W-1:0]         w_lookup_ctr;
  logic [GHR_W-1:0]         w_ghr_next;
  logic                     w_unused_pc;
  logic [GHR_W-1:0]         r_ghr;
  logic [STAT_W-1:0]        r_branch_cnt;
  logic [STAT_W-1:0]        r_mispred_cnt;

  assign w_pc_idx    = lookup_pc_i[IDX_W+1:2];
  assign w_unused_pc = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

  generate
    if (MODE == 1) begin : g_gshare
      assign w_lookup_idx = w_pc_idx ^ IDX_W'(r_ghr);
      if (GHR_W > 1) begin : g_shift
        assign w_ghr_next = {r_ghr[GHR_W-2:0], update_taken_i};
      end else begin : g_single
        assign w_ghr_next = update_taken_i;
      end
    end else begin : g_bimodal
      assign w_lookup_idx = w_pc_idx;
      assign w_ghr_next   = '0;
    end
  endgenerate

  // One counter per entry; only the entry named by update_idx_i moves.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [CTR_W-1:0] r_ctr;
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          r_ctr <= CTR_W'(INIT_CTR);
        end else if (update_valid_i && update_idx_i == IDX_W'(gi)) begin
          if (update_taken_i && r_ctr != CTR_MAX)
            r_ctr <= r_ctr + 1'b1;
          else if (!update_taken_i && r_ctr != '0)
            r_ctr <= r_ctr - 1'b1;
        end
      end
      assign w_ctr_flat[gi*CTR_W +: CTR_W] = r_ctr;
    end
  endgenerate

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign w_lookup_ctr    = w_ctr_flat[w_lookup_idx*CTR_W +: CTR_W];
  assign predict_taken_o = w_lookup_ctr[CTR_W-1];
  assign predict_idx_o   = w_lookup_idx;
  assign mispredict_o    = update_valid_i & (update_taken_i != update_pred_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ghr         <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (update_valid_i) begin
      r_ghr <= w_ghr_next;
      if (r_branch_cnt != STAT_MAX)
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (mispredict_o && r_mispred_cnt != STAT_MAX)
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign ghr_o         = r_ghr;
  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal, gshare and narrow-statistics instances share
// one stimulus stream and are each checked against a behavioural model every cycle.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        update_valid_i = 1'b0;
  logic [3:0]  update_idx_i = '0;
  logic        update_taken_i = 1'b0;
  logic        update_pred_i = 1'b0;

  always #5 clk_i = ~clk_i;

  logic        pt0, pt1, pt2, mp0, mp1, mp2;
  logic [3:0]  idx0, idx1, idx2, ghr0, ghr1, ghr2;
  logic [15:0] bc0, mc0, bc1, mc1;
  logic [2:0]  bc2, mc2;

  branch_predictor #(.MODE(0)) u_bim (
    .clk_i(clk_i), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .predict_taken_o(pt0), .predict_idx_o(idx0),
    .update_valid_i(update_valid_i), .update_idx_i(update_idx_i),
    .update_taken_i(update_taken_i), .update_pred_i(update_pred_i),
    .mispredict_o(mp0), .ghr_o(ghr0), .branch_cnt_o(bc0), .mispred_cnt_o(mc0));

  branch_predictor #(.MODE(1)) u_gsh (
    .clk_i(clk_i), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .predict_taken_o(pt1), .predict_idx_o(idx1),
    .update_valid_i(update_valid_i), .update_idx_i(update_idx_i),
    .update_taken_i(update_taken_i), .update_pred_i(update_pred_i),
    .mispredict_o(mp1), .ghr_o(ghr1), .branch_cnt_o(bc1), .mispred_cnt_o(mc1));

  branch_predictor #(.MODE(0), .STAT_W(3)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .predict_taken_o(pt2), .predict_idx_o(idx2),
    .update_valid_i(update_valid_i), .update_idx_i(update_idx_i),
    .update_taken_i(update_taken_i), .update_pred_i(update_pred_i),
    .mispredict_o(mp2), .ghr_o(ghr2), .branch_cnt_o(bc2), .mispred_cnt_o(mc2));

  logic [31:0] a_pt[3], a_idx[3], a_mp[3], a_ghr[3], a_bc[3], a_mc[3];
  always_comb begin
    a_pt[0] = 32'(pt0);  a_pt[1] = 32'(pt1);  a_pt[2] = 32'(pt2);
    a_idx[0] = 32'(idx0); a_idx[1] = 32'(idx1); a_idx[2] = 32'(idx2);
    a_mp[0] = 32'(mp0);  a_mp[1] = 32'(mp1);  a_mp[2] = 32'(mp2);
    a_ghr[0] = 32'(ghr0); a_ghr[1] = 32'(ghr1); a_ghr[2] = 32'(ghr2);
    a_bc[0] = 32'(bc0);  a_bc[1] = 32'(bc1);  a_bc[2] = 32'(bc2);
    a_mc[0] = 32'(mc0);  a_mc[1] = 32'(mc1);  a_mc[2] = 32'(mc2);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers in [0,3], history as a number mod 16.
  localparam int MODE_OF [3] = '{0, 1, 0};
  localparam int STAT_MAX [3] = '{65535, 65535, 7};
  int m_ctr [3][16];
  int m_ghr [3];
  int m_bc [3];
  int m_mc [3];
  bit m_valid = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 3; k++) begin
        for (int e = 0; e < 16; e++) m_ctr[k][e] = 2;
        m_ghr[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
      end
      m_valid = 1'b1;
    end else if (update_valid_i) begin
      for (int k = 0; k < 3; k++) begin
        int e;
        e = int'(update_idx_i);
        if (update_taken_i) m_ctr[k][e] = (m_ctr[k][e] < 3) ? m_ctr[k][e] + 1 : 3;
        else                m_ctr[k][e] = (m_ctr[k][e] > 0) ? m_ctr[k][e] - 1 : 0;
        if (MODE_OF[k] == 1) m_ghr[k] = (m_ghr[k] * 2 + int'(update_taken_i)) % 16;
        if (m_bc[k] < STAT_MAX[k]) m_bc[k]++;
        if (update_taken_i != update_pred_i && m_mc[k] < STAT_MAX[k]) m_mc[k]++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        int e;
        e = (int'(lookup_pc_i) / 4) % 16;
        if (MODE_OF[k] == 1) e = e ^ m_ghr[k];
        chk("model_idx", k, a_idx[k], 32'(e));
        chk("model_pt", k, a_pt[k], (m_ctr[k][e] >= 2) ? 32'd1 : 32'd0);
        chk("model_mp", k, a_mp[k],
            (update_valid_i && update_taken_i != update_pred_i) ? 32'd1 : 32'd0);
        chk("model_ghr", k, a_ghr[k], 32'(m_ghr[k]));
        chk("model_bc", k, a_bc[k], 32'(m_bc[k]));
        chk("model_mc", k, a_mc[k], 32'(m_mc[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    $display("reset applied");
  endtask

  task automatic upd(input logic [3:0] idx, input logic t, input logic p);
    update_valid_i = 1'b1; update_idx_i = idx; update_taken_i = t; update_pred_i = p;
    $display("update idx=%0d taken=%0b pred=%0b", idx, t, p);
    tick();
    update_valid_i = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc_i = pc;
    #2;
    $display("lookup pc=%08h bim_pt=%0b gsh_idx=%0d", pc, pt0, idx1);
  endtask

  logic [31:0] pcs [3] = '{32'h00, 32'h04, 32'h3C};

  initial begin
    // Reset defaults
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      look(pcs[i]);
      chk("t1_pt", 0, a_pt[0], 32'd1);
      chk("t1_bc", 0, a_bc[0], 32'd0);
    end

    // Bimodal saturation at idx 5 (pc 0x14)
    upd(4'd5, 1, 1); upd(4'd5, 1, 1); upd(4'd5, 1, 1);
    look(32'h14); chk("t2_sat_hi", 0, a_pt[0], 32'd1);
    upd(4'd5, 0, 1);
    look(32'h14); chk("t2_ctr2", 0, a_pt[0], 32'd1);
    upd(4'd5, 0, 1); upd(4'd5, 0, 1);
    look(32'h14); chk("t2_ctr0", 0, a_pt[0], 32'd0);
    upd(4'd5, 0, 0); upd(4'd5, 1, 0);
    look(32'h14); chk("t2_sat_lo", 0, a_pt[0], 32'd0);

    // Same-cycle lookup and update at idx 2
    upd(4'd2, 0, 1);
    update_valid_i = 1'b1; update_idx_i = 4'd2; update_taken_i = 1'b1; update_pred_i = 1'b0;
    look(32'h08); chk("t3_same", 0, a_pt[0], 32'd0);
    tick();
    update_valid_i = 1'b0;
    look(32'h08); chk("t3_next", 0, a_pt[0], 32'd1);

    // Gshare history and index
    do_reset();
    upd(4'd0, 1, 1); upd(4'd0, 1, 1); upd(4'd0, 0, 1);
    look(32'h20);
    chk("t4_ghr", 1, a_ghr[1], 32'h6);
    chk("t4_idx", 1, a_idx[1], 32'd14);
    chk("t4_bim_ghr", 0, a_ghr[0], 32'd0);

    // Statistics saturation on STAT_W=3 instance
    do_reset();
    for (int i = 0; i < 10; i++) begin
      update_valid_i = 1'b1; update_idx_i = 4'(i); update_taken_i = i[0]; update_pred_i = ~i[0];
      #2;
      chk("t5_mp", 2, a_mp[2], 32'd1);
      $display("update idx=%0d taken=%0b pred=%0b", i, update_taken_i, update_pred_i);
      tick();
    end
    update_valid_i = 1'b0;
    #2;
    chk("t5_bc", 2, a_bc[2], 32'd7);
    chk("t5_mc", 2, a_mc[2], 32'd7);
    chk("t5_bc16", 0, a_bc[0], 32'd10);

    // Reset beats a concurrent update
    do_reset();
    upd(4'd1, 0, 1);
    look(32'h04); chk("t6_pre", 0, a_pt[0], 32'd0);
    rst_i = 1'b0;
    update_valid_i = 1'b1; update_idx_i = 4'd1; update_taken_i = 1'b1; update_pred_i = 1'b0;
    tick();
    rst_i = 1'b1; update_valid_i = 1'b0;
    look(32'h04);
    chk("t6_pt", 0, a_pt[0], 32'd1);
    chk("t6_ghr", 1, a_ghr[1], 32'd0);
    chk("t6_bc", 0, a_bc[0], 32'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
